// File: rtl/oled_spi_receiver_pkg.sv
// Shared types for the OLED SPI receiver: field widths, controller opcodes
// and the command-decoder state enum.
package oled_spi_receiver_pkg;

    localparam int BYTE_W = 8;
    localparam int PAGE_W = 2;
    localparam int COL_W  = 7;
    localparam int ADDR_W = PAGE_W + COL_W;

    typedef enum logic [1:0] {
        ST_CMD,
        ST_ARG_SKIP,
        ST_ARG_COL_START,
        ST_ARG_COL_END
    } cmdState_t;

    localparam logic [7:0] OP_DISP_OFF    = 8'hAE;
    localparam logic [7:0] OP_DISP_ON     = 8'hAF;
    localparam logic [7:0] OP_COL_ADDR    = 8'h21;
    localparam logic [7:0] OP_CONTRAST    = 8'h81;
    localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
    localparam logic [7:0] OP_MUX_RATIO   = 8'hA8;
    localparam logic [7:0] OP_CLK_DIV     = 8'hD5;
    localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
    localparam logic [7:0] OP_COM_PINS    = 8'hDA;
    localparam logic [7:0] OP_VCOMH       = 8'hDB;

    // Commands followed by exactly one argument byte that this model discards.
    function automatic logic hasOneArg(input logic [7:0] op);
        return (op == OP_CONTRAST)   || (op == OP_CHARGE_PUMP) ||
               (op == OP_MUX_RATIO)  || (op == OP_CLK_DIV)     ||
               (op == OP_PRECHARGE)  || (op == OP_COM_PINS)    ||
               (op == OP_VCOMH);
    endfunction

endpackage

// File: rtl/oled_spi_receiver_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus rising-edge detect
// on the synchronized level.
module oled_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pinIn,
    output logic rise
);

    logic [SYNC_STAGES-1:0] syncChain;
    logic                   prevLevel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncChain <= '0;
            prevLevel <= 1'b0;
        end else begin
            syncChain <= {syncChain[SYNC_STAGES-2:0], pinIn};
            prevLevel <= syncChain[SYNC_STAGES-1];
        end
    end

    assign rise = syncChain[SYNC_STAGES-1] & ~prevLevel;

endmodule

// File: rtl/oled_spi_receiver.sv
// Passive SPI sniffer for an SSD1306-style OLED link: assembles bytes, tracks
// the command state and write cursor, and mirrors data bytes into a GDDRAM copy.
module oled_spi_receiver
    import oled_spi_receiver_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_PAGES   = 4,
    parameter int NUM_COLS    = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              oledSCLK,
    input  logic              oledSDIN,
    input  logic              oledDC,
    input  logic              oledRES,
    output logic              byteValid,
    output logic [BYTE_W-1:0] byteData,
    output logic              byteIsData,
    output logic              dispOn,
    output logic              frameDone,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [BYTE_W-1:0] rdData
);

    localparam int DEPTH = NUM_PAGES * NUM_COLS;
    localparam logic [ADDR_W:0]   DEPTH_L    = (ADDR_W+1)'(DEPTH);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(NUM_COLS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST  = PAGE_W'(NUM_PAGES - 1);

    // ---- stage p0: pin synchronizers ----
    logic                          sclkRise;
    logic [SYNC_STAGES-1:0][2:0]   pinChain;
    logic                          sdinS, dcS, resS;

    oled_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSclkSync (
        .clk   (clk),
        .rst   (rst),
        .pinIn (oledSCLK),
        .rise  (sclkRise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pinChain <= '0;
        else      pinChain <= {pinChain[SYNC_STAGES-2:0], {oledSDIN, oledDC, oledRES}};
    end

    assign sdinS = pinChain[SYNC_STAGES-1][2];
    assign dcS   = pinChain[SYNC_STAGES-1][1];
    assign resS  = pinChain[SYNC_STAGES-1][0];

    // ---- stage p1: bit assembly ----
    logic [BYTE_W-1:0] shiftReg;
    logic [2:0]        bitCnt;
    logic [BYTE_W-1:0] rxByte;
    logic              byteVld_p1;

    assign rxByte = {shiftReg[BYTE_W-2:0], sdinS};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shiftReg   <= '0;
            bitCnt     <= '0;
            byteData   <= '0;
            byteIsData <= 1'b0;
            byteVld_p1 <= 1'b0;
        end else if (!resS) begin
            shiftReg   <= '0;
            bitCnt     <= '0;
            byteVld_p1 <= 1'b0;
        end else begin
            byteVld_p1 <= 1'b0;
            if (sclkRise) begin
                shiftReg <= rxByte;
                bitCnt   <= bitCnt + 3'd1;
                if (bitCnt == 3'd7) begin
                    byteData   <= rxByte;
                    byteIsData <= dcS;
                    byteVld_p1 <= 1'b1;
                end
            end
        end
    end

    assign byteValid = byteVld_p1 & resS;

    // ---- stage p2: command decode and cursor ----
    logic      cmdValid, dataValid;
    cmdState_t state, nextState;
    logic      dispOnSet, dispOffSet, pageLoad, colLoLoad, colHiLoad;
    logic      colStartLoad, colEndLoad;

    assign cmdValid  = byteValid & ~byteIsData;
    assign dataValid = byteValid &  byteIsData;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_CMD;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        if (!resS) begin
            nextState = ST_CMD;
        end else if (cmdValid) begin
            case (state)
                ST_CMD: begin
                    if (byteData == OP_COL_ADDR)  nextState = ST_ARG_COL_START;
                    else if (hasOneArg(byteData)) nextState = ST_ARG_SKIP;
                end
                ST_ARG_SKIP:      nextState = ST_CMD;
                ST_ARG_COL_START: nextState = ST_ARG_COL_END;
                ST_ARG_COL_END:   nextState = ST_CMD;
                default:          nextState = ST_CMD;
            endcase
        end
    end

    always_comb begin
        dispOnSet    = 1'b0;
        dispOffSet   = 1'b0;
        pageLoad     = 1'b0;
        colLoLoad    = 1'b0;
        colHiLoad    = 1'b0;
        colStartLoad = 1'b0;
        colEndLoad   = 1'b0;
        if (cmdValid) begin
            case (state)
                ST_CMD: begin
                    dispOnSet  = (byteData == OP_DISP_ON);
                    dispOffSet = (byteData == OP_DISP_OFF);
                    pageLoad   = (byteData[7:2] == 6'b101100);
                    colLoLoad  = (byteData[7:4] == 4'h0);
                    colHiLoad  = (byteData[7:3] == 5'b00010);
                end
                ST_ARG_COL_START: colStartLoad = 1'b1;
                ST_ARG_COL_END:   colEndLoad   = 1'b1;
                default: ;
            endcase
        end
    end

    logic [PAGE_W-1:0] page;
    logic [COL_W-1:0]  col, colStart, colEnd;
    logic [ADDR_W-1:0] wrAddr;
    logic              colWrap;

    assign wrAddr    = {page, col};
    assign colWrap   = (col == colEnd);
    assign frameDone = dataValid & colWrap & (page == PAGE_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dispOn   <= 1'b0;
            page     <= '0;
            col      <= '0;
            colStart <= '0;
            colEnd   <= COL_LAST;
        end else if (!resS) begin
            dispOn   <= 1'b0;
            page     <= '0;
            col      <= '0;
            colStart <= '0;
            colEnd   <= COL_LAST;
        end else begin
            if (dataValid) begin
                if (colWrap) begin
                    col  <= colStart;
                    page <= (page == PAGE_LAST) ? '0 : page + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (dispOnSet)  dispOn <= 1'b1;
            if (dispOffSet) dispOn <= 1'b0;
            if (pageLoad)   page <= byteData[PAGE_W-1:0];
            if (colLoLoad)  col[3:0] <= byteData[3:0];
            if (colHiLoad)  col[6:4] <= byteData[2:0];
            if (colStartLoad) begin
                colStart <= byteData[COL_W-1:0];
                col      <= byteData[COL_W-1:0];
            end
            if (colEndLoad) colEnd <= byteData[COL_W-1:0];
        end
    end

    // GDDRAM mirror survives both resets; reads return pre-write contents.
    logic [BYTE_W-1:0] gddram [DEPTH];

    always_ff @(posedge clk) begin
        if (dataValid && ({1'b0, wrAddr} < DEPTH_L)) gddram[wrAddr] <= byteData;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                            rdData <= '0;
        else if ({1'b0, rdAddr} < DEPTH_L)   rdData <= gddram[rdAddr];
    end

endmodule

// File: tb/tb_oled_spi_receiver.sv
// Directed bench for oled_spi_receiver with a byte scoreboard fed by stimulus.
module tb_oled_spi_receiver;

    localparam int PH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       oledSCLK, oledSDIN, oledDC, oledRES;
    logic       byteValid, byteIsData, dispOn, frameDone;
    logic [7:0] byteData, rdData;
    logic [8:0] rdAddr;

    int nCompared = 0;
    int nMismatch = 0;
    int fdCount   = 0;
    logic [8:0] expQ [$];

    always #5 clk = ~clk;

    oled_spi_receiver dut (
        .clk        (clk),
        .rst        (rst),
        .oledSCLK   (oledSCLK),
        .oledSDIN   (oledSDIN),
        .oledDC     (oledDC),
        .oledRES    (oledRES),
        .byteValid  (byteValid),
        .byteData   (byteData),
        .byteIsData (byteIsData),
        .dispOn     (dispOn),
        .frameDone  (frameDone),
        .rdAddr     (rdAddr),
        .rdData     (rdData)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every byteValid must match the oldest expected byte.
    always @(negedge clk) begin
        if (byteValid !== 1'b0) begin
            if (expQ.size() == 0) begin
                check("unexpected_byteValid", {23'd0, byteIsData, byteData}, 32'h1FF);
            end else begin
                logic [8:0] e;
                e = expQ.pop_front();
                check("byte", {23'd0, byteIsData, byteData}, {23'd0, e});
            end
        end
        if (frameDone === 1'b1) fdCount++;
    end

    task automatic sendBits(input logic [7:0] b, input logic dc, input int nBits);
        for (int i = 0; i < nBits; i++) begin
            oledSDIN = b[7-i];
            oledDC   = dc;
            repeat (PH) @(negedge clk);
            oledSCLK = 1'b1;
            repeat (PH) @(negedge clk);
            oledSCLK = 1'b0;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b, input logic dc);
        expQ.push_back({dc, b});
        sendBits(b, dc, 8);
    endtask

    task automatic readMem(input string name, input logic [8:0] a, input logic [7:0] exp);
        rdAddr = a;
        @(posedge clk);
        @(negedge clk);
        check(name, {24'd0, rdData}, {24'd0, exp});
    endtask

    task automatic pulseRes();
        oledRES = 1'b0;
        repeat (10) @(negedge clk);
        oledRES = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    initial begin
        rst = 1'b0; oledSCLK = 1'b0; oledSDIN = 1'b0; oledDC = 1'b0; oledRES = 1'b1;
        rdAddr = '0;
        repeat (3) @(negedge clk);
        check("rst_byteValid",  {31'd0, byteValid},  32'd0);
        check("rst_byteData",   {24'd0, byteData},   32'd0);
        check("rst_byteIsData", {31'd0, byteIsData}, 32'd0);
        check("rst_dispOn",     {31'd0, dispOn},     32'd0);
        check("rst_frameDone",  {31'd0, frameDone},  32'd0);
        check("rst_rdData",     {24'd0, rdData},     32'd0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_dispOn", {31'd0, dispOn}, 32'd0);

        // Display on, then a skipped argument that looks like display-off.
        sendByte(8'hAF, 1'b0);
        check("dispOn_after_AF", {31'd0, dispOn}, 32'd1);
        sendByte(8'h81, 1'b0);
        sendByte(8'hAE, 1'b0);
        check("dispOn_arg_skipped", {31'd0, dispOn}, 32'd1);
        sendByte(8'hAE, 1'b0);
        check("dispOn_after_AE", {31'd0, dispOn}, 32'd0);

        // Page 2, column 0x35, two data bytes.
        sendByte(8'hB2, 1'b0);
        sendByte(8'h05, 1'b0);
        sendByte(8'h13, 1'b0);
        sendByte(8'hA5, 1'b1);
        sendByte(8'h5A, 1'b1);
        readMem("mem_135", 9'h135, 8'hA5);
        readMem("mem_136", 9'h136, 8'h5A);

        // Column window 0x7E..0x7F wraps into the next page.
        sendByte(8'hB0, 1'b0);
        sendByte(8'h21, 1'b0);
        sendByte(8'h7E, 1'b0);
        sendByte(8'h7F, 1'b0);
        sendByte(8'h11, 1'b1);
        sendByte(8'h22, 1'b1);
        sendByte(8'h33, 1'b1);
        readMem("mem_07E", 9'h07E, 8'h11);
        readMem("mem_07F", 9'h07F, 8'h22);
        readMem("mem_0FE", 9'h0FE, 8'h33);

        // Display reset restores the cursor and window; full frame wraps once.
        sendByte(8'hAF, 1'b0);
        pulseRes();
        check("dispOn_after_RES", {31'd0, dispOn}, 32'd0);
        readMem("mem_kept_135", 9'h135, 8'hA5);
        fdCount = 0;
        for (int i = 0; i < 511; i++) sendByte(pat(i), 1'b1);
        check("frameDone_before_last", fdCount, 32'd0);
        sendByte(pat(511), 1'b1);
        check("frameDone_on_512", fdCount, 32'd1);
        readMem("frame_000", 9'h000, pat(0));
        readMem("frame_080", 9'h080, pat(128));
        readMem("frame_1FF", 9'h1FF, pat(511));
        sendByte(8'hEE, 1'b1);
        readMem("cursor_wrapped", 9'h000, 8'hEE);
        readMem("cursor_next_free", 9'h001, pat(1));

        // System reset mid-byte drops the partial bits.
        sendBits(8'hFF, 1'b0, 3);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        sendByte(8'hAF, 1'b0);
        check("dispOn_after_rst_midbyte", {31'd0, dispOn}, 32'd1);

        // Display reset mid-byte drops the partial bits and clears dispOn.
        sendBits(8'hFF, 1'b0, 3);
        pulseRes();
        sendByte(8'h3C, 1'b0);
        check("dispOn_after_RES_midbyte", {31'd0, dispOn}, 32'd0);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", expQ.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
